// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state encoding and sizing for the factorial accelerator
package fact_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MULT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } fact_state_t;

  localparam int FACT_NW    = 4;
  localparam int FACT_WIDTH = 32;
  localparam int FACT_NMAX  = 12;

endpackage

// File: rtl/fact_dp.sv
// rtl/fact_dp.sv - factorial datapath: down-counter, running product and loop compares
module fact_dp
  import fact_pkg::*;
#(
  parameter int NW    = FACT_NW,
  parameter int WIDTH = FACT_WIDTH,
  parameter int NMAX  = FACT_NMAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [NW-1:0]    n_in,
  output logic [WIDTH-1:0] prod,
  output logic             cnt_gt_max,
  output logic             cnt_le_1
);

  localparam logic [NW-1:0] NMAX_C = NW'(NMAX);
  localparam logic [NW-1:0] ONE_C  = NW'(1);

  logic [NW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_q, prod_d;

  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load) begin
      cnt_d  = n_in;
      prod_d = WIDTH'(1);
    end else if (step) begin
      cnt_d  = cnt_q - ONE_C;
      prod_d = prod_q * {{(WIDTH-NW){1'b0}}, cnt_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prod_q <= WIDTH'(1);
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign prod       = prod_q;
  assign cnt_gt_max = (cnt_q > NMAX_C);
  assign cnt_le_1   = (cnt_q <= ONE_C);

endmodule

// File: rtl/fact_ctrl.sv
// rtl/fact_ctrl.sv - factorial sequencing FSM and status decode
// Optional completion interrupt pulse when FACT_IRQ_EN is defined.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int NW    = FACT_NW,
  parameter int WIDTH = FACT_WIDTH,
  parameter int NMAX  = FACT_NMAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             irq
);

  fact_state_t      state_q, state_d;
  logic             load, step;
  logic             cnt_gt_max, cnt_le_1;
  logic [WIDTH-1:0] prod;

  fact_dp #(.NW(NW), .WIDTH(WIDTH), .NMAX(NMAX)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .n_in       (n),
    .prod       (prod),
    .cnt_gt_max (cnt_gt_max),
    .cnt_le_1   (cnt_le_1)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (go) begin
          load    = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cnt_gt_max)    state_d = ERR;
        else if (cnt_le_1) state_d = DONE;
        else               state_d = MULT;
      end
      MULT: begin
        step    = 1'b1;
        state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign busy   = (state_q == CHECK) || (state_q == MULT);
  assign done   = (state_q == DONE);
  assign err    = (state_q == ERR);
  assign result = done ? prod : '0;

`ifdef FACT_IRQ_EN
  // Only CHECK can enter DONE/ERR, so this marks the first terminal cycle.
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (state_q == CHECK) && ((state_d == DONE) || (state_d == ERR));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fact_ctrl.sv
// tb/tb_fact_ctrl.sv - self-checking bench for fact_ctrl
module tb_fact_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [3:0]  n;
  logic        busy, done, err, irq;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef FACT_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  fact_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     nv;
    longint res;
    bit     er;
  } vec_t;

  vec_t tbl[8];

  function automatic longint fact_m(input int k);
    longint r = 1;
    if (k > 12) return 0;
    for (int i = 2; i <= k; i++) r = r * i;
    return r;
  endfunction

  // Cycles from the accepting edge until the terminal state is sampled at an edge.
  function automatic int lat_m(input int k);
    if (k <= 1 || k > 12) return 2;
    return 2 * k;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one computation; optionally pulse a stray go (n=2) at cycle inject, then hold.
  task automatic do_op(input int nv, input longint exp_res, input bit exp_err,
                       input int inject, input int hold, input string tag);
    int  lat;
    bit  early;
    lat   = lat_m(nv);
    early = 1'b0;
    @(negedge clk);
    n  = 4'(nv);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    n  = 4'($urandom);
    chk({tag, "_busy"}, busy, 1);
    for (int c = 1; c <= lat - 1; c++) begin
      if (c == inject) begin
        go = 1'b1;
        n  = 4'd2;
      end
      @(posedge clk);
      #1;
      go = 1'b0;
      if (c < lat - 1 && (done || err || irq || !busy)) early = 1'b1;
    end
    chk({tag, "_early"}, early, 0);
    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_result"}, result, exp_err ? 0 : exp_res);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_irq1"}, irq, IRQ_ON);
    @(posedge clk);
    #1;
    chk({tag, "_irq0"}, irq, 0);
    if (hold > 0) begin
      bit held = 1'b1;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        if (done !== !exp_err || err !== exp_err || busy !== 1'b0 ||
            result !== 32'(exp_err ? 0 : exp_res)) held = 1'b0;
      end
      chk({tag, "_hold"}, held, 1);
    end
  endtask

  initial begin
    tbl[0] = '{0, 1, 0};
    tbl[1] = '{1, 1, 0};
    tbl[2] = '{2, 2, 0};
    tbl[3] = '{5, 120, 0};
    tbl[4] = '{7, 5040, 0};
    tbl[5] = '{12, 479001600, 0};
    tbl[6] = '{13, 0, 1};
    tbl[7] = '{15, 0, 1};

    rst = 1'b1;
    go  = 1'b0;
    n   = 4'd0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_irq", irq, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].nv, tbl[i].res, tbl[i].er, 0, 0, $sformatf("tbl%0d", i));

    do_op(5, 120, 0, 0, 20, "hold5");
    do_op(6, 720, 0, 3, 0, "ignore6");
    do_op(4, 24, 0, lat_m(4) - 1, 3, "doneedge4");
    do_op(4, 24, 0, 0, 0, "irq4");
    do_op(13, 0, 1, 0, 5, "errhold");

    // Reset while the n=7 loop is in flight must wipe every visible output.
    @(negedge clk);
    n  = 4'd7;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3, 6, 0, 0, 0, "afterrst");

    for (int i = 0; i < 30; i++) begin
      int k, inj;
      k   = $urandom_range(0, 15);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat_m(k) - 1) : 0;
      do_op(k, fact_m(k), k > 12, inj, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
